// File: rtl/axi4lite_cmd_master.sv
// axi4lite_cmd_master
//   AXI4-Lite initiator. Single-beat commands from a valid/ready command port
//   become AXI4-Lite write or read transactions; the slave's response (and read
//   data) is returned on a valid/ready response port. One transaction is
//   outstanding at a time. A hung slave is abandoned after TIMEOUT_CYCLES.
// Ports
//   M_AXI_ACLK, M_AXI_ARESET     clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake; cmd_we selects write/read
//   cmd_addr/cmd_wdata/cmd_wstrb command fields (data/strobes unused on reads)
//   rsp_valid/rsp_ready          response handshake
//   rsp_resp/rsp_rdata           BRESP/RRESP and RDATA (0 for writes/timeouts)
//   rsp_timeout                  slave did not complete in time
//   M_AXI_*                      AXI4-Lite master channels AW, W, B, AR, R
module axi4lite_cmd_master #(
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ADDR_WIDTH = 6,
   parameter int TIMEOUT_CYCLES     = 256
) (
   input  logic                              M_AXI_ACLK,
   input  logic                              M_AXI_ARESET,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic                              cmd_we,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [1:0]                        rsp_resp,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic                              rsp_timeout,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                        M_AXI_AWPROT,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                        M_AXI_ARPROT,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_DATA, RSP} state_t;

   state_t                            state, state_nxt;
   logic [TW-1:0]                     tcnt, tcnt_nxt;
   logic                              active;
   logic                              cmd_ready_nxt;
   logic [C_M_AXI_ADDR_WIDTH-1:0]     awaddr_nxt, araddr_nxt;
   logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_nxt, rsp_rdata_nxt;
   logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_nxt;
   logic                              awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
   logic                              rsp_valid_nxt, rsp_timeout_nxt;
   logic [1:0]                        rsp_resp_nxt;

   assign M_AXI_AWPROT = 3'b000;
   assign M_AXI_ARPROT = 3'b000;

   assign active = (state == WR_ISSUE) || (state == WR_RESP) ||
                   (state == RD_ISSUE) || (state == RD_DATA);

   always_comb begin
      state_nxt       = state;
      tcnt_nxt        = tcnt;
      cmd_ready_nxt   = 1'b0;
      awaddr_nxt      = M_AXI_AWADDR;
      araddr_nxt      = M_AXI_ARADDR;
      wdata_nxt       = M_AXI_WDATA;
      wstrb_nxt       = M_AXI_WSTRB;
      awvalid_nxt     = M_AXI_AWVALID;
      wvalid_nxt      = M_AXI_WVALID;
      bready_nxt      = M_AXI_BREADY;
      arvalid_nxt     = M_AXI_ARVALID;
      rready_nxt      = M_AXI_RREADY;
      rsp_valid_nxt   = rsp_valid;
      rsp_resp_nxt    = rsp_resp;
      rsp_rdata_nxt   = rsp_rdata;
      rsp_timeout_nxt = rsp_timeout;

      if (active) tcnt_nxt = tcnt + 1'b1;

      case (state)
         IDLE: begin
            cmd_ready_nxt = 1'b1;
            if (cmd_valid && cmd_ready) begin
               cmd_ready_nxt = 1'b0;
               tcnt_nxt      = '0;
               awaddr_nxt    = cmd_addr;
               araddr_nxt    = cmd_addr;
               wdata_nxt     = cmd_wdata;
               wstrb_nxt     = cmd_wstrb;
               if (cmd_we) begin
                  state_nxt   = WR_ISSUE;
                  awvalid_nxt = 1'b1;
                  wvalid_nxt  = 1'b1;
               end else begin
                  state_nxt   = RD_ISSUE;
                  arvalid_nxt = 1'b1;
               end
            end
         end
         WR_ISSUE: begin
            // A channel whose valid is already low finished its handshake earlier.
            if (M_AXI_AWVALID && M_AXI_AWREADY) awvalid_nxt = 1'b0;
            if (M_AXI_WVALID && M_AXI_WREADY) wvalid_nxt = 1'b0;
            if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
               state_nxt  = WR_RESP;
               bready_nxt = 1'b1;
            end
         end
         WR_RESP: begin
            if (M_AXI_BVALID && M_AXI_BREADY) begin
               bready_nxt      = 1'b0;
               rsp_valid_nxt   = 1'b1;
               rsp_resp_nxt    = M_AXI_BRESP;
               rsp_rdata_nxt   = '0;
               rsp_timeout_nxt = 1'b0;
               state_nxt       = RSP;
            end
         end
         RD_ISSUE: begin
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
               arvalid_nxt = 1'b0;
               rready_nxt  = 1'b1;
               state_nxt   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (M_AXI_RVALID && M_AXI_RREADY) begin
               rready_nxt      = 1'b0;
               rsp_valid_nxt   = 1'b1;
               rsp_resp_nxt    = M_AXI_RRESP;
               rsp_rdata_nxt   = M_AXI_RDATA;
               rsp_timeout_nxt = 1'b0;
               state_nxt       = RSP;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               cmd_ready_nxt = 1'b1;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Hung-slave escape: a response beat accepted on the final cycle still
      // wins; otherwise every AXI valid/ready is withdrawn unconditionally.
      if (active && (tcnt == TW'(TIMEOUT_CYCLES - 1)) && (state_nxt != RSP)) begin
         awvalid_nxt     = 1'b0;
         wvalid_nxt      = 1'b0;
         bready_nxt      = 1'b0;
         arvalid_nxt     = 1'b0;
         rready_nxt      = 1'b0;
         rsp_valid_nxt   = 1'b1;
         rsp_resp_nxt    = 2'b10;
         rsp_rdata_nxt   = '0;
         rsp_timeout_nxt = 1'b1;
         state_nxt       = RSP;
      end
   end

   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         state         <= IDLE;
         tcnt          <= '0;
         cmd_ready     <= 1'b0;
         M_AXI_AWADDR  <= '0;
         M_AXI_ARADDR  <= '0;
         M_AXI_WDATA   <= '0;
         M_AXI_WSTRB   <= '0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_BREADY  <= 1'b0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY  <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_resp      <= '0;
         rsp_rdata     <= '0;
         rsp_timeout   <= 1'b0;
      end else begin
         state         <= state_nxt;
         tcnt          <= tcnt_nxt;
         cmd_ready     <= cmd_ready_nxt;
         M_AXI_AWADDR  <= awaddr_nxt;
         M_AXI_ARADDR  <= araddr_nxt;
         M_AXI_WDATA   <= wdata_nxt;
         M_AXI_WSTRB   <= wstrb_nxt;
         M_AXI_AWVALID <= awvalid_nxt;
         M_AXI_WVALID  <= wvalid_nxt;
         M_AXI_BREADY  <= bready_nxt;
         M_AXI_ARVALID <= arvalid_nxt;
         M_AXI_RREADY  <= rready_nxt;
         rsp_valid     <= rsp_valid_nxt;
         rsp_resp      <= rsp_resp_nxt;
         rsp_rdata     <= rsp_rdata_nxt;
         rsp_timeout   <= rsp_timeout_nxt;
      end
   end

endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// tb_axi4lite_cmd_master
//   Directed bench for axi4lite_cmd_master. A cycle-stepped slave with a small
//   register memory answers each transaction; its response arrives one cycle
//   after the address (and data) handshakes plus an optional extra delay.
module tb_axi4lite_cmd_master;

   localparam int DW = 32;
   localparam int AW = 6;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            cmd_valid, cmd_ready, cmd_we;
   logic [AW-1:0]   cmd_addr;
   logic [DW-1:0]   cmd_wdata;
   logic [3:0]      cmd_wstrb;
   logic            rsp_valid, rsp_ready, rsp_timeout;
   logic [1:0]      rsp_resp;
   logic [DW-1:0]   rsp_rdata;
   logic [AW-1:0]   M_AXI_AWADDR, M_AXI_ARADDR;
   logic [2:0]      M_AXI_AWPROT, M_AXI_ARPROT;
   logic            M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic [DW-1:0]   M_AXI_WDATA, M_AXI_RDATA;
   logic [3:0]      M_AXI_WSTRB;
   logic [1:0]      M_AXI_BRESP, M_AXI_RRESP;
   logic            M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic            M_AXI_RVALID, M_AXI_RREADY;
   logic            any_out;

   logic [DW-1:0]   mem [64];
   int              tests_run    = 0;
   int              tests_failed = 0;

   always #5 clk = ~clk;

   axi4lite_cmd_master #(
      .C_M_AXI_DATA_WIDTH(DW),
      .C_M_AXI_ADDR_WIDTH(AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
      .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   assign any_out = cmd_ready | rsp_valid | (|rsp_resp) | (|rsp_rdata) | rsp_timeout |
                    (|M_AXI_AWADDR) | (|M_AXI_AWPROT) | M_AXI_AWVALID | (|M_AXI_WDATA) |
                    (|M_AXI_WSTRB) | M_AXI_WVALID | M_AXI_BREADY | (|M_AXI_ARADDR) |
                    (|M_AXI_ARPROT) | M_AXI_ARVALID | M_AXI_RREADY;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic slave_idle();
      M_AXI_AWREADY = 1'b0;
      M_AXI_WREADY  = 1'b0;
      M_AXI_ARREADY = 1'b0;
      M_AXI_BVALID  = 1'b0;
      M_AXI_BRESP   = 2'b00;
      M_AXI_RVALID  = 1'b0;
      M_AXI_RRESP   = 2'b00;
      M_AXI_RDATA   = '0;
   endtask

   // One command from issue to response handshake. aw_dly also sets the
   // ARREADY delay for reads; resp_dly delays BVALID/RVALID further.
   task automatic run_txn(input string name, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int resp_dly,
                          input logic [1:0] sresp, input int hold, input int exp_lat,
                          input logic [1:0] exp_resp, input logic [DW-1:0] exp_rdata,
                          input logic exp_to);
      int cyc = 1, aw_seen = 0, w_seen = 0, ar_seen = 0, aw_hs = 0, w_hs = 0, ar_hs = 0;
      int done_cyc = 0, held = 0, lat = 0;
      logic resp_taken = 0, got = 0, hs = 0, bad_field = 0, early = 0, unstable = 0, busy = 0;
      logic [1:0] r_resp = '0;
      logic [DW-1:0] r_rdata = '0;
      logic r_to = 0;

      @(negedge clk);
      check({name, " cmd_ready before"}, cmd_ready, 1);
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
      @(negedge clk);
      cmd_valid = 1'b0;
      check({name, " cmd_ready after accept"}, cmd_ready, 0);

      while (!hs && cyc <= 60) begin
         if ((M_AXI_BREADY || M_AXI_RREADY) && done_cyc == 0) early = 1;
         M_AXI_AWREADY = M_AXI_AWVALID && (aw_seen >= aw_dly);
         if (M_AXI_AWVALID) begin
            aw_seen++;
            if (M_AXI_AWADDR !== addr) bad_field = 1;
            if (M_AXI_AWREADY) aw_hs++;
         end
         M_AXI_WREADY = M_AXI_WVALID && (w_seen >= w_dly);
         if (M_AXI_WVALID) begin
            w_seen++;
            if (M_AXI_WDATA !== wdata || M_AXI_WSTRB !== strb) bad_field = 1;
            if (M_AXI_WREADY) w_hs++;
         end
         M_AXI_ARREADY = M_AXI_ARVALID && (ar_seen >= aw_dly);
         if (M_AXI_ARVALID) begin
            ar_seen++;
            if (M_AXI_ARADDR !== addr) bad_field = 1;
            if (M_AXI_ARREADY) ar_hs++;
         end
         if (done_cyc == 0 && ((aw_hs > 0 && w_hs > 0) || ar_hs > 0)) done_cyc = cyc;

         M_AXI_BVALID = we && done_cyc > 0 && !resp_taken && cyc >= done_cyc + 2 + resp_dly;
         M_AXI_BRESP  = sresp;
         if (M_AXI_BVALID && M_AXI_BREADY) begin
            resp_taken = 1;
            if (sresp == 2'b00)
               for (int b = 0; b < 4; b++)
                  if (strb[b]) mem[addr][8*b +: 8] = wdata[8*b +: 8];
         end
         M_AXI_RVALID = !we && done_cyc > 0 && !resp_taken && cyc >= done_cyc + 2 + resp_dly;
         M_AXI_RRESP  = sresp;
         M_AXI_RDATA  = mem[addr];
         if (M_AXI_RVALID && M_AXI_RREADY) resp_taken = 1;

         if (rsp_valid) begin
            if (!got) begin
               got = 1; lat = cyc;
               r_resp = rsp_resp; r_rdata = rsp_rdata; r_to = rsp_timeout;
               if (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_ARVALID || M_AXI_BREADY || M_AXI_RREADY)
                  busy = 1;
            end else if (rsp_resp !== r_resp || rsp_rdata !== r_rdata || rsp_timeout !== r_to) begin
               unstable = 1;
            end
            if (cmd_ready) unstable = 1;
            rsp_ready = (held >= hold);
            held++;
            hs = rsp_ready;
         end else if (got) begin
            unstable = 1;
         end
         @(negedge clk);
         cyc++;
      end
      rsp_ready = 1'b0;
      slave_idle();

      check({name, " rsp handshake within bound"}, hs, 1);
      check({name, " rsp latency"}, lat, exp_lat);
      check({name, " rsp_resp"}, r_resp, exp_resp);
      check({name, " rsp_rdata"}, r_rdata, exp_rdata);
      check({name, " rsp_timeout"}, r_to, exp_to);
      check({name, " axi quiet at rsp"}, busy, 0);
      check({name, " rsp held stable"}, unstable, 0);
      check({name, " ready before issue done"}, early, 0);
      check({name, " addr/data fields"}, bad_field, 0);
      if (we) begin
         check({name, " awvalid cycles"}, aw_seen, exp_to ? TO : aw_dly + 1);
         check({name, " wvalid cycles"}, w_seen, exp_to ? TO : w_dly + 1);
         check({name, " aw handshakes"}, aw_hs, exp_to ? 0 : 1);
         check({name, " w handshakes"}, w_hs, exp_to ? 0 : 1);
      end else begin
         check({name, " arvalid cycles"}, ar_seen, aw_dly + 1);
         check({name, " ar handshakes"}, ar_hs, 1);
      end
      check({name, " rsp_valid after handshake"}, rsp_valid, 0);
      check({name, " cmd_ready after handshake"}, cmd_ready, 1);
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 1'b0;
      slave_idle();
      #1;
      check("reset outputs zero", any_out, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      //      name  we   addr   wdata         strb     awd  wd  rd  sresp  hold lat resp   rdata         to
      run_txn("t1", 1'b1, 6'h00, 32'hA1A1A1A1, 4'hF,   0,   0,  0,  2'b00, 0,   4,  2'b00, 32'h0,        1'b0);
      run_txn("t2", 1'b1, 6'h01, 32'hB2B2B2B2, 4'hF,   3,   0,  0,  2'b00, 0,   7,  2'b00, 32'h0,        1'b0);
      run_txn("t3", 1'b0, 6'h01, 32'h0,        4'h0,   0,   0,  2,  2'b00, 0,   6,  2'b00, 32'hB2B2B2B2, 1'b0);
      run_txn("t4", 1'b1, 6'h0C, 32'hC3C3C3C3, 4'hF,   0,   0,  0,  2'b10, 5,   4,  2'b10, 32'h0,        1'b0);
      run_txn("t7", 1'b1, 6'h01, 32'h11223344, 4'b0101, 0,  0,  0,  2'b00, 0,   4,  2'b00, 32'h0,        1'b0);
      run_txn("t8", 1'b0, 6'h01, 32'h0,        4'h0,   0,   0,  0,  2'b00, 1,   4,  2'b00, 32'hB222B244, 1'b0);
      run_txn("t5", 1'b1, 6'h02, 32'h00000005, 4'hF,   1000, 1000, 0, 2'b00, 0, 17, 2'b10, 32'h0,        1'b1);

      // Reset in the middle of a write address phase.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 6'h3; cmd_wdata = 32'hEEEEEEEE; cmd_wstrb = 4'hF;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("t6 awvalid before reset", M_AXI_AWVALID, 1);
      #2 rst = 1'b1;
      #1 check("t6 outputs cleared by reset", any_out, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("t6 cmd_ready after release", cmd_ready, 1);
      check("t6 no response after reset", rsp_valid, 0);
      run_txn("t6w", 1'b1, 6'h03, 32'hD4D4D4D4, 4'hF,  0,   0,  0,  2'b00, 0,   4,  2'b00, 32'h0,        1'b0);
      run_txn("t6r", 1'b0, 6'h03, 32'h0,        4'h0,  0,   0,  0,  2'b00, 0,   4,  2'b00, 32'hD4D4D4D4, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
